// File: rtl/seg7_scan_driver.sv
// Multiplexed six-digit seven-segment scanner for an HH:MM:SS display.
// Digits are latched once per frame and shown one slot at a time, with dead time, leading-zero blanking and blink.
module seg7_scan_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int DEAD_CYC  = 2,
    parameter int BLINK_DIV = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hour_h,
    input  logic [3:0] hour_l,
    input  logic [3:0] minute_h,
    input  logic [3:0] minute_l,
    input  logic [3:0] second_h,
    input  logic [3:0] second_l,
    input  logic [5:0] blink_mask,
    input  logic       blank_lead,
    output logic [6:0] seg,
    output logic [5:0] dig_sel,
    output logic       frame_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CW-1:0]      cnt, cnt_nxt;
    logic [2:0]         idx, idx_nxt;
    logic [FW-1:0]      fcnt, fcnt_nxt;
    logic               blink_phase, phase_nxt;
    logic [5:0][3:0]    sh_dig, sh_dig_nxt;
    logic [5:0]         sh_mask, sh_mask_nxt;
    logic               sh_lead, sh_lead_nxt;
    logic               step, snap;
    logic [3:0]         cur;
    logic [6:0]         seg_nxt;
    logic [5:0]         dig_sel_nxt;

    always_comb begin
        step        = (cnt == CW'(SCAN_DIV - 1));
        cnt_nxt     = step ? '0 : cnt + 1'b1;
        idx_nxt     = idx;
        if (step) begin
            idx_nxt = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end
        snap        = step && (idx == 3'd5);

        sh_dig_nxt  = sh_dig;
        sh_mask_nxt = sh_mask;
        sh_lead_nxt = sh_lead;
        fcnt_nxt    = fcnt;
        phase_nxt   = blink_phase;
        if (snap) begin
            // entry 0 is hour_h so the array index equals the slot index
            sh_dig_nxt  = {second_l, second_h, minute_l, minute_h, hour_l, hour_h};
            sh_mask_nxt = blink_mask;
            sh_lead_nxt = blank_lead;
            if (fcnt == FW'(BLINK_DIV - 1)) begin
                fcnt_nxt  = '0;
                phase_nxt = ~blink_phase;
            end else begin
                fcnt_nxt  = fcnt + 1'b1;
            end
        end

        // outputs reflect the state this edge is about to load
        cur = sh_dig_nxt[idx_nxt];
        case (cur)
            4'd0:    seg_nxt = 7'b1000000;
            4'd1:    seg_nxt = 7'b1111001;
            4'd2:    seg_nxt = 7'b0100100;
            4'd3:    seg_nxt = 7'b0110000;
            4'd4:    seg_nxt = 7'b0011001;
            4'd5:    seg_nxt = 7'b0010010;
            4'd6:    seg_nxt = 7'b0000010;
            4'd7:    seg_nxt = 7'b1111000;
            4'd8:    seg_nxt = 7'b0000000;
            4'd9:    seg_nxt = 7'b0010000;
            default: seg_nxt = 7'b1111111;
        endcase
        if (idx_nxt == 3'd0 && sh_lead_nxt && cur == 4'd0) begin
            seg_nxt = 7'b1111111;
        end
        if (phase_nxt && sh_mask_nxt[3'd5 - idx_nxt]) begin
            seg_nxt = 7'b1111111;
        end

        dig_sel_nxt = 6'b111111;
        if (int'(cnt_nxt) >= DEAD_CYC) begin
            dig_sel_nxt[3'd5 - idx_nxt] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= 3'd0;
            fcnt        <= '0;
            blink_phase <= 1'b0;
            sh_dig      <= '0;
            sh_mask     <= '0;
            sh_lead     <= 1'b0;
            frame_tick  <= 1'b0;
            seg         <= 7'b1111111;
            dig_sel     <= 6'b111111;
        end else begin
            cnt         <= cnt_nxt;
            idx         <= idx_nxt;
            fcnt        <= fcnt_nxt;
            blink_phase <= phase_nxt;
            sh_dig      <= sh_dig_nxt;
            sh_mask     <= sh_mask_nxt;
            sh_lead     <= sh_lead_nxt;
            frame_tick  <= snap;
            seg         <= seg_nxt;
            dig_sel     <= dig_sel_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: reference model driven by edge count since reset,
// fixed vector table, hand-written corner sequences and randomized input traffic.
module tb_seg7_scan_driver;

    localparam int SD    = 4;
    localparam int DC    = 1;
    localparam int BD    = 2;
    localparam int FRAME = 6 * SD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_dig [6];
    logic [5:0] in_mask;
    logic       in_bl;
    logic [6:0] seg;
    logic [5:0] dig_sel;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    // reference model: position in the scan follows directly from edges since reset
    int         n;
    bit         fresh;
    int         frames;
    logic [3:0] m_dig [6];
    logic [5:0] m_mask;
    logic       m_bl;
    logic [6:0] seg_tab [10];

    typedef struct packed {
        logic [3:0] d0, d1, d2, d3, d4, d5;
        logic       bl;
        logic [2:0] slot;
        logic [6:0] seg;
        logic [5:0] dig;
    } vec_t;
    vec_t vecs [12];

    seg7_scan_driver #(.SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_DIV(BD)) dut (
        .clk        (clk),
        .rst        (rst),
        .hour_h     (in_dig[0]),
        .hour_l     (in_dig[1]),
        .minute_h   (in_dig[2]),
        .minute_l   (in_dig[3]),
        .second_h   (in_dig[4]),
        .second_l   (in_dig[5]),
        .blink_mask (in_mask),
        .blank_lead (in_bl),
        .seg        (seg),
        .dig_sel    (dig_sel),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        checks++;
        a_onehot: assert ($onehot0(~dig_sel)) else begin
            errors++;
            $display("FAIL dig_sel_onehot t=%0t got %b required all-high or one low", $time, dig_sel);
        end
    end

    task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s n=%0d got %b exp %b", name, n, got, exp);
        end
    endtask

    function automatic logic [6:0] model_seg();
        int slot;
        logic [3:0] d;
        if (fresh) return 7'b1111111;
        slot = (n / SD) % 6;
        d = m_dig[slot];
        if (d > 4'd9) return 7'b1111111;
        if (slot == 0 && m_bl && d == 4'd0) return 7'b1111111;
        if (((frames / BD) % 2) == 1 && m_mask[5 - slot]) return 7'b1111111;
        return seg_tab[d];
    endfunction

    function automatic logic [5:0] model_dig();
        logic [5:0] r;
        r = 6'b111111;
        if (!fresh && (n % SD) >= DC) r[5 - ((n / SD) % 6)] = 1'b0;
        return r;
    endfunction

    task automatic reset_model();
        n = 0;
        fresh = 1;
        frames = 0;
        for (int k = 0; k < 6; k++) m_dig[k] = 4'd0;
        m_mask = 6'd0;
        m_bl = 1'b0;
    endtask

    task automatic compare_all();
        logic exp_tick;
        exp_tick = !fresh && n > 0 && (n % FRAME) == 0;
        chk("seg", seg, model_seg());
        chk("dig_sel", {1'b0, dig_sel}, {1'b0, model_dig()});
        chk("frame_tick", {6'd0, frame_tick}, {6'd0, exp_tick});
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            n++;
            fresh = 0;
            if (n % FRAME == 0) begin
                for (int k = 0; k < 6; k++) m_dig[k] = in_dig[k];
                m_mask = in_mask;
                m_bl = in_bl;
                frames++;
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_abs(input int target);
        int g;
        g = 0;
        while (n < target && g < 400) begin
            tick();
            g++;
        end
        checks++;
        if (n != target) begin
            errors++;
            $display("FAIL run_abs_timeout n=%0d required %0d", n, target);
        end
    endtask

    task automatic run_mod(input int target);
        int g;
        g = 0;
        do begin
            tick();
            g++;
        end while ((n % FRAME) != target && g < 400);
        checks++;
        if ((n % FRAME) != target) begin
            errors++;
            $display("FAIL run_mod_timeout n=%0d required phase %0d", n, target);
        end
    endtask

    task automatic set_digits(input int a, b, c, d, e, f);
        in_dig[0] = 4'(a); in_dig[1] = 4'(b); in_dig[2] = 4'(c);
        in_dig[3] = 4'(d); in_dig[4] = 4'(e); in_dig[5] = 4'(f);
    endtask

    task automatic sync_reset();
        rst = 1'b1;
        reset_model();
        tick();
        rst = 1'b0;
    endtask

    logic [6:0] frame_seg [6];

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;

        vecs[0]  = '{4'd1, 4'd2, 4'd3, 4'd4,  4'd5, 4'd6,  1'b0, 3'd0, 7'b1111001, 6'b011111};
        vecs[1]  = '{4'd1, 4'd2, 4'd3, 4'd4,  4'd5, 4'd6,  1'b0, 3'd1, 7'b0100100, 6'b101111};
        vecs[2]  = '{4'd1, 4'd2, 4'd3, 4'd4,  4'd5, 4'd6,  1'b0, 3'd5, 7'b0000010, 6'b111110};
        vecs[3]  = '{4'd0, 4'd2, 4'd3, 4'd4,  4'd5, 4'd6,  1'b1, 3'd0, 7'b1111111, 6'b011111};
        vecs[4]  = '{4'd0, 4'd2, 4'd3, 4'd4,  4'd5, 4'd6,  1'b0, 3'd0, 7'b1000000, 6'b011111};
        vecs[5]  = '{4'd1, 4'd2, 4'd3, 4'd4,  4'd5, 4'd12, 1'b0, 3'd5, 7'b1111111, 6'b111110};
        vecs[6]  = '{4'd7, 4'd8, 4'd9, 4'd0,  4'd1, 4'd2,  1'b0, 3'd0, 7'b1111000, 6'b011111};
        vecs[7]  = '{4'd7, 4'd8, 4'd9, 4'd0,  4'd1, 4'd2,  1'b0, 3'd1, 7'b0000000, 6'b101111};
        vecs[8]  = '{4'd7, 4'd8, 4'd9, 4'd0,  4'd1, 4'd2,  1'b0, 3'd2, 7'b0010000, 6'b110111};
        vecs[9]  = '{4'd5, 4'd2, 4'd3, 4'd4,  4'd5, 4'd6,  1'b1, 3'd0, 7'b0010010, 6'b011111};
        vecs[10] = '{4'd1, 4'd2, 4'd3, 4'd15, 4'd5, 4'd6,  1'b0, 3'd3, 7'b1111111, 6'b111011};
        vecs[11] = '{4'd0, 4'd0, 4'd0, 4'd0,  4'd0, 4'd0,  1'b1, 3'd1, 7'b1000000, 6'b101111};

        frame_seg[0] = 7'b1111001; frame_seg[1] = 7'b0100100; frame_seg[2] = 7'b0110000;
        frame_seg[3] = 7'b0011001; frame_seg[4] = 7'b0010010; frame_seg[5] = 7'b0000010;

        set_digits(1, 2, 3, 4, 5, 6);
        in_mask = 6'd0;
        in_bl   = 1'b0;
        rst     = 1'b1;
        reset_model();
        @(negedge clk);
        chk("rst_seg", seg, 7'b1111111);
        chk("rst_dig_sel", {1'b0, dig_sel}, 7'b0111111);
        chk("rst_frame_tick", {6'd0, frame_tick}, 7'd0);
        tick();
        rst = 1'b0;

        // scan order over the second frame
        run_abs(FRAME);
        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < SD; c++) begin
                if (c < DC) begin
                    chk("scan_dead", {1'b0, dig_sel}, 7'b0111111);
                end else begin
                    chk("scan_dig", {1'b0, dig_sel}, {1'b0, ~(6'b100000 >> s)});
                    chk("scan_seg", seg, frame_seg[s]);
                end
                tick();
            end
        end

        // an input change mid-frame waits for the next snapshot
        run_mod(2 * SD + DC);
        in_dig[3] = 4'd9;
        run_mod(3 * SD + DC);
        chk("snap_old", seg, 7'b0011001);
        run_mod(3 * SD + DC);
        chk("snap_new", seg, 7'b0010000);

        // asynchronous reset in the middle of slot 3
        run_mod(3 * SD + 2);
        #2 rst = 1'b1;
        #1;
        chk("async_seg", seg, 7'b1111111);
        chk("async_dig_sel", {1'b0, dig_sel}, 7'b0111111);
        chk("async_tick", {6'd0, frame_tick}, 7'd0);
        reset_model();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_slot0_seg", seg, 7'b1000000);
        chk("post_rst_slot0_dig", {1'b0, dig_sel}, 7'b0011111);
        run_abs(2 * SD + DC);
        chk("post_rst_zero_shadow", seg, 7'b1000000);

        // blink: two frames dark, two frames lit, only masked digits
        set_digits(1, 2, 3, 4, 5, 6);
        in_mask = 6'b000011;
        sync_reset();
        for (int f = 1; f <= 7; f++) begin
            run_abs(f * FRAME + DC);
            chk("blink_other", seg, 7'b1111001);
            run_abs(f * FRAME + 4 * SD + DC);
            chk("blink_sec_h", seg, (((f / BD) % 2) == 1) ? 7'b1111111 : 7'b0010010);
            run_abs(f * FRAME + 5 * SD + DC);
            chk("blink_sec_l", seg, (((f / BD) % 2) == 1) ? 7'b1111111 : 7'b0000010);
        end
        in_mask = 6'd0;

        foreach (vecs[i]) begin
            set_digits(vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3, vecs[i].d4, vecs[i].d5);
            in_bl = vecs[i].bl;
            run_mod(0);
            run_mod(int'(vecs[i].slot) * SD + DC);
            chk("vec_seg", seg, vecs[i].seg);
            chk("vec_dig_sel", {1'b0, dig_sel}, {1'b0, vecs[i].dig});
        end

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                sync_reset();
            end else begin
                if ($urandom_range(0, 7) == 0) begin
                    int k;
                    k = int'($urandom_range(0, 7));
                    if (k < 6) in_dig[k] = 4'($urandom_range(0, 15));
                    else if (k == 6) in_mask = 6'($urandom_range(0, 63));
                    else in_bl = 1'($urandom_range(0, 1));
                end
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
